// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// pipe_pkg : shared types and constants for the pipeline hazard controller
// Rev 1.0
// ============================================================================
package pipe_pkg;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic en;
    logic flush;
  } stage_ctrl_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// sat_counter : W-bit up counter that holds at all-ones
// Rev 1.0
// ============================================================================
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// pipe_hazard_ctrl : stall/flush sequencing for the five-stage MIPS pipeline
// Rev 1.0
// ============================================================================
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int DMEM_MAX_WAIT = 15,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_uses_rt,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_wreg,
  input  logic             MEM_Branch,
  input  logic             MEM_zero,
  input  logic             MEM_MemRead,
  input  logic             MEM_MemWrite,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             PC_en,
  output logic             IFID_en,
  output logic             IDEX_en,
  output logic             EXMEM_en,
  output logic             MEMWB_en,
  output logic             IFID_flush,
  output logic             IDEX_flush,
  output logic             EXMEM_flush,
  output logic             MEMWB_flush,
  output logic             PC_src,
  output logic             dmem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int                WAIT_W     = $clog2(DMEM_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] C_WAIT_MAX = WAIT_W'(DMEM_MAX_WAIT);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;

  stage_ctrl_t ifid_c, idex_c, exmem_c, memwb_c;
  logic        pc_en_c;
  logic        pc_src_c;
  logic        req_c;
  logic        flush_inc_c;

  logic w_mem_op;
  logic w_taken;
  logic w_load_use;
  logic w_stall_inc;

  assign w_mem_op   = MEM_MemRead | MEM_MemWrite;
  assign w_taken    = MEM_Branch & MEM_zero;
  assign w_load_use = EX_MemRead && (EX_wreg != REG_ZERO) &&
                      ((EX_wreg == ID_rs) || (ID_uses_rt && (EX_wreg == ID_rt)));

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
    pc_en_c     = 1'b1;
    ifid_c      = '{en: 1'b1, flush: 1'b0};
    idex_c      = '{en: 1'b1, flush: 1'b0};
    exmem_c     = '{en: 1'b1, flush: 1'b0};
    memwb_c     = '{en: 1'b1, flush: 1'b0};
    pc_src_c    = 1'b0;
    req_c       = 1'b0;
    flush_inc_c = 1'b0;

    case (state_q)
      INIT: begin
        pc_en_c       = 1'b0;
        ifid_c.flush  = 1'b1;
        idex_c.flush  = 1'b1;
        exmem_c.flush = 1'b1;
        memwb_c.flush = 1'b1;
        state_d       = RUN;
      end

      RUN: begin
        req_c = w_mem_op;
        if (w_mem_op && !dmem_ack) begin
          // Freeze everything up to MEM; the bubble into WB keeps it from retiring twice
          pc_en_c       = 1'b0;
          ifid_c.en     = 1'b0;
          idex_c.en     = 1'b0;
          exmem_c.en    = 1'b0;
          memwb_c.flush = 1'b1;
          wait_cnt_d    = '0;
          state_d       = MEM_WAIT;
        end else if (w_taken) begin
          pc_src_c      = 1'b1;
          ifid_c.flush  = 1'b1;
          idex_c.flush  = 1'b1;
          exmem_c.flush = 1'b1;
          flush_inc_c   = 1'b1;
        end else if (w_load_use) begin
          pc_en_c      = 1'b0;
          ifid_c.en    = 1'b0;
          idex_c.flush = 1'b1;
        end
      end

      MEM_WAIT: begin
        req_c = w_mem_op;
        if (wait_cnt_q != C_WAIT_MAX) begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
        if (wait_cnt_d == C_WAIT_MAX) begin
          timeout_d = 1'b1;
        end
        if (dmem_ack) begin
          state_d = RUN;
        end else begin
          pc_en_c       = 1'b0;
          ifid_c.en     = 1'b0;
          idex_c.en     = 1'b0;
          exmem_c.en    = 1'b0;
          memwb_c.flush = 1'b1;
        end
      end

      default: begin
        state_d = INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign w_stall_inc = !pc_en_c && (state_q != INIT);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc_c),
    .count (flush_cnt)
  );

  assign dmem_req     = req_c;
  assign PC_en        = pc_en_c;
  assign IFID_en      = ifid_c.en;
  assign IDEX_en      = idex_c.en;
  assign EXMEM_en     = exmem_c.en;
  assign MEMWB_en     = memwb_c.en;
  assign IFID_flush   = ifid_c.flush;
  assign IDEX_flush   = idex_c.flush;
  assign EXMEM_flush  = exmem_c.flush;
  assign MEMWB_flush  = memwb_c.flush;
  assign PC_src       = pc_src_c;
  assign dmem_timeout = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pipe_hazard_ctrl : vector table plus scoreboard bench for pipe_hazard_ctrl
// Rev 1.0
// ============================================================================
module tb_pipe_hazard_ctrl;

  // {dmem_req, PC_en, IFID/IDEX/EXMEM/MEMWB_en, IFID/IDEX/EXMEM/MEMWB_flush, PC_src}
  localparam logic [10:0] C_INIT   = 11'b00_1111_1111_0;
  localparam logic [10:0] C_IDLE   = 11'b01_1111_0000_0;
  localparam logic [10:0] C_LU     = 11'b00_0111_0100_0;
  localparam logic [10:0] C_BR     = 11'b01_1111_1110_1;
  localparam logic [10:0] C_FRZ    = 11'b10_0001_0001_0;
  localparam logic [10:0] C_MACK   = 11'b11_1111_0000_0;
  localparam logic [10:0] C_MACKBR = 11'b11_1111_1110_1;

  typedef struct {
    string       name;
    logic        ex_rd;
    logic [4:0]  wreg;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        uses_rt;
    logic        br;
    logic        zero;
    logic        mrd;
    logic        mwr;
    logic        ack;
    logic [10:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [10:0] exp;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  ID_rs = '0, ID_rt = '0, EX_wreg = '0;
  logic        ID_uses_rt = 1'b0, EX_MemRead = 1'b0;
  logic        MEM_Branch = 1'b0, MEM_zero = 1'b0;
  logic        MEM_MemRead = 1'b0, MEM_MemWrite = 1'b0, dmem_ack = 1'b0;
  logic        dmem_req, PC_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en;
  logic        IFID_flush, IDEX_flush, EXMEM_flush, MEMWB_flush, PC_src;
  logic        dmem_timeout;
  logic [31:0] stall_cnt, flush_cnt;
  logic [10:0] act;

  int checks = 0;
  int errors = 0;
  sb_t sb[$];
  vec_t tbl[13];

  pipe_hazard_ctrl #(.DMEM_MAX_WAIT(15), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
    .EX_MemRead(EX_MemRead), .EX_wreg(EX_wreg),
    .MEM_Branch(MEM_Branch), .MEM_zero(MEM_zero),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .dmem_ack(dmem_ack), .dmem_req(dmem_req),
    .PC_en(PC_en), .IFID_en(IFID_en), .IDEX_en(IDEX_en),
    .EXMEM_en(EXMEM_en), .MEMWB_en(MEMWB_en),
    .IFID_flush(IFID_flush), .IDEX_flush(IDEX_flush),
    .EXMEM_flush(EXMEM_flush), .MEMWB_flush(MEMWB_flush),
    .PC_src(PC_src), .dmem_timeout(dmem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  assign act = {dmem_req, PC_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en,
                IFID_flush, IDEX_flush, EXMEM_flush, MEMWB_flush, PC_src};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard consumer: outputs are combinational, so sample mid-cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_t e;
      e = sb.pop_front();
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
      end
    end
  end

  function automatic vec_t mk(input string n, input logic ex_rd, input logic [4:0] wreg,
                              input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                              input logic br, input logic zero, input logic mrd,
                              input logic mwr, input logic ack, input logic [10:0] exp);
    vec_t v;
    v.name = n; v.ex_rd = ex_rd; v.wreg = wreg; v.rs = rs; v.rt = rt;
    v.uses_rt = uses_rt; v.br = br; v.zero = zero; v.mrd = mrd; v.mwr = mwr;
    v.ack = ack; v.exp = exp;
    return v;
  endfunction

  // Drive one cycle of inputs right after a rising edge and queue the expectation
  task automatic step(input vec_t v);
    sb_t e;
    EX_MemRead = v.ex_rd; EX_wreg = v.wreg; ID_rs = v.rs; ID_rt = v.rt;
    ID_uses_rt = v.uses_rt; MEM_Branch = v.br; MEM_zero = v.zero;
    MEM_MemRead = v.mrd; MEM_MemWrite = v.mwr; dmem_ack = v.ack;
    e.name = v.name; e.exp = v.exp;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = mk("idle",         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE);
    tbl[1]  = mk("lu_rs",        1, 8, 8, 0, 0, 0, 0, 0, 0, 0, C_LU);
    tbl[2]  = mk("lu_wreg0",     1, 0, 0, 0, 1, 0, 0, 0, 0, 0, C_IDLE);
    tbl[3]  = mk("lu_rt_unused", 1, 8, 3, 8, 0, 0, 0, 0, 0, 0, C_IDLE);
    tbl[4]  = mk("lu_rt_used",   1, 8, 3, 8, 1, 0, 0, 0, 0, 0, C_LU);
    tbl[5]  = mk("no_load",      0, 8, 8, 8, 1, 0, 0, 0, 0, 0, C_IDLE);
    tbl[6]  = mk("branch",       0, 0, 0, 0, 0, 1, 1, 0, 0, 0, C_BR);
    tbl[7]  = mk("branch_lu",    1, 8, 8, 0, 0, 1, 1, 0, 0, 0, C_BR);
    tbl[8]  = mk("br_not_taken", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, C_IDLE);
    tbl[9]  = mk("nt_lu",        1, 9, 9, 0, 0, 1, 0, 0, 0, 0, C_LU);
    tbl[10] = mk("mem_ack0",     0, 0, 0, 0, 0, 0, 0, 1, 0, 1, C_MACK);
    tbl[11] = mk("memwr_ack_br", 0, 0, 0, 0, 0, 1, 1, 0, 1, 1, C_MACKBR);
    tbl[12] = mk("ack_no_req",   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_IDLE);

    // Reset state
    #2;
    check("rst_outputs", 32'(act), 32'(C_INIT));
    check("rst_stall", stall_cnt, 32'd0);
    check("rst_flush", flush_cnt, 32'd0);
    check("rst_timeout", 32'(dmem_timeout), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    step(mk("init_cycle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_INIT));
    check("init_stall", stall_cnt, 32'd0);
    step(mk("run_cycle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE));

    for (int i = 0; i < 13; i++) step(tbl[i]);
    check("tbl_stall", stall_cnt, 32'd3);
    check("tbl_flush", flush_cnt, 32'd3);

    // Memory read with ack after 3 wait cycles, load-use pending throughout
    for (int i = 0; i < 3; i++) step(mk("mem_freeze", 1, 8, 8, 0, 0, 0, 0, 1, 0, 0, C_FRZ));
    step(mk("mem_release", 1, 8, 8, 0, 0, 0, 0, 1, 0, 1, C_MACK));
    check("mem_stall", stall_cnt, 32'd6);
    step(mk("lu_after_ack", 1, 8, 8, 0, 0, 0, 0, 0, 0, 0, C_LU));
    step(mk("idle_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE));
    check("mem_lu_stall", stall_cnt, 32'd7);
    check("no_timeout_yet", 32'(dmem_timeout), 32'd0);

    // Wait-limit: timeout appears after the 15th MEM_WAIT cycle
    for (int i = 0; i < 20; i++) begin
      step(mk("long_wait", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_FRZ));
      if (i == 14) check("timeout_c15", 32'(dmem_timeout), 32'd0);
      if (i == 15) check("timeout_c16", 32'(dmem_timeout), 32'd1);
    end
    step(mk("long_release", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, C_MACK));
    step(mk("idle_post_to", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE));
    check("timeout_sticky", 32'(dmem_timeout), 32'd1);
    check("timeout_stall", stall_cnt, 32'd27);

    // Reset asserted in the middle of a wait
    step(mk("pre_rst_frz", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_FRZ));
    step(mk("pre_rst_wait", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_FRZ));
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", 32'(act), 32'(C_INIT));
    check("midrst_req", 32'(dmem_req), 32'd0);
    check("midrst_stall", stall_cnt, 32'd0);
    check("midrst_flush", flush_cnt, 32'd0);
    check("midrst_timeout", 32'(dmem_timeout), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(mk("reinit", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_INIT));
    step(mk("rerun", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE));

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
